// File: rtl/fsm_flow_ctrl.sv
// Flow-control FSM: captures and validates FIFO watermarks during INIT, then
// tracks IDLE/ACTIVE from the empty flags and parks in a sticky ERROR state.
module fsm_flow_ctrl #(
    parameter int TH_W   = 5,
    parameter int N_FIFO = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [TH_W-1:0]   main_fifo_low,
    input  logic [TH_W-1:0]   main_fifo_high,
    input  logic [TH_W-1:0]   vc0_low,
    input  logic [TH_W-1:0]   vc0_high,
    input  logic [TH_W-1:0]   vc1_low,
    input  logic [TH_W-1:0]   vc1_high,
    input  logic [TH_W-1:0]   d0_low,
    input  logic [TH_W-1:0]   d0_high,
    input  logic [TH_W-1:0]   d1_low,
    input  logic [TH_W-1:0]   d1_high,
    input  logic [N_FIFO-1:0] empties,
    input  logic [N_FIFO-1:0] errors,
    output logic [2:0]        state,
    output logic [TH_W-1:0]   main_fifo_low_out,
    output logic [TH_W-1:0]   main_fifo_high_out,
    output logic [TH_W-1:0]   vc0_low_out,
    output logic [TH_W-1:0]   vc0_high_out,
    output logic [TH_W-1:0]   vc1_low_out,
    output logic [TH_W-1:0]   vc1_high_out,
    output logic [TH_W-1:0]   d0_low_out,
    output logic [TH_W-1:0]   d0_high_out,
    output logic [TH_W-1:0]   d1_low_out,
    output logic [TH_W-1:0]   d1_high_out,
    output logic              idle_out,
    output logic              active_out,
    output logic              error_out,
    output logic [N_FIFO-1:0] error_code,
    output logic              cfg_err
);
    localparam int N_TH = 5;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t cur_state, nxt_state;

    logic [TH_W-1:0] lo_in [N_TH];
    logic [TH_W-1:0] hi_in [N_TH];
    logic [TH_W-1:0] lo_q  [N_TH];
    logic [TH_W-1:0] hi_q  [N_TH];
    logic            cfg_bad;
    logic            any_err;

    assign lo_in[0] = main_fifo_low;
    assign hi_in[0] = main_fifo_high;
    assign lo_in[1] = vc0_low;
    assign hi_in[1] = vc0_high;
    assign lo_in[2] = vc1_low;
    assign hi_in[2] = vc1_high;
    assign lo_in[3] = d0_low;
    assign hi_in[3] = d0_high;
    assign lo_in[4] = d1_low;
    assign hi_in[4] = d1_high;

    assign any_err = |errors;

    // Checked against the values being latched on the INIT exit edge.
    always_comb begin
        cfg_bad = 1'b0;
        for (int i = 0; i < N_TH; i++) begin
            if (lo_in[i] > hi_in[i]) cfg_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_RESET;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_RESET: nxt_state = S_INIT;
            S_ERROR: nxt_state = S_ERROR;
            default: begin
                if (any_err)   nxt_state = S_ERROR;
                else if (init) nxt_state = S_INIT;
                else begin
                    case (cur_state)
                        S_INIT:   nxt_state = cfg_bad ? S_ERROR : S_IDLE;
                        S_IDLE:   if (empties != '1) nxt_state = S_ACTIVE;
                        S_ACTIVE: if (empties == '1) nxt_state = S_IDLE;
                        default:  nxt_state = S_RESET;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        state      = cur_state;
        idle_out   = (cur_state == S_IDLE);
        active_out = (cur_state == S_ACTIVE);
        error_out  = (cur_state == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TH; i++) begin
                lo_q[i] <= '0;
                hi_q[i] <= '0;
            end
            error_code <= '0;
            cfg_err    <= 1'b0;
        end else begin
            if (cur_state == S_INIT) begin
                for (int i = 0; i < N_TH; i++) begin
                    lo_q[i] <= lo_in[i];
                    hi_q[i] <= hi_in[i];
                end
                if (!any_err && !init && cfg_bad) cfg_err <= 1'b1;
            end
            if (nxt_state == S_ERROR) error_code <= error_code | errors;
        end
    end

    assign main_fifo_low_out  = lo_q[0];
    assign main_fifo_high_out = hi_q[0];
    assign vc0_low_out        = lo_q[1];
    assign vc0_high_out       = hi_q[1];
    assign vc1_low_out        = lo_q[2];
    assign vc1_high_out       = hi_q[2];
    assign d0_low_out         = lo_q[3];
    assign d0_high_out        = hi_q[3];
    assign d1_low_out         = lo_q[4];
    assign d1_high_out        = hi_q[4];
endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// Bench for fsm_flow_ctrl: directed steps followed by random traffic, all
// checked against a small behavioural model of the flow-control rules.
module tb_fsm_flow_ctrl;
    logic       clk;
    logic       reset;
    logic       init;
    logic [4:0] lo_i [5];
    logic [4:0] hi_i [5];
    logic [4:0] empties;
    logic [4:0] errors;
    wire  [2:0] state;
    wire  [4:0] lo_o [5];
    wire  [4:0] hi_o [5];
    wire        idle_out, active_out, error_out, cfg_err;
    wire  [4:0] error_code;

    fsm_flow_ctrl #(.TH_W(5), .N_FIFO(5)) dut (
        .clk(clk), .reset(reset), .init(init),
        .main_fifo_low(lo_i[0]), .main_fifo_high(hi_i[0]),
        .vc0_low(lo_i[1]), .vc0_high(hi_i[1]),
        .vc1_low(lo_i[2]), .vc1_high(hi_i[2]),
        .d0_low(lo_i[3]), .d0_high(hi_i[3]),
        .d1_low(lo_i[4]), .d1_high(hi_i[4]),
        .empties(empties), .errors(errors),
        .state(state),
        .main_fifo_low_out(lo_o[0]), .main_fifo_high_out(hi_o[0]),
        .vc0_low_out(lo_o[1]), .vc0_high_out(hi_o[1]),
        .vc1_low_out(lo_o[2]), .vc1_high_out(hi_o[2]),
        .d0_low_out(lo_o[3]), .d0_high_out(hi_o[3]),
        .d1_low_out(lo_o[4]), .d1_high_out(hi_o[4]),
        .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
        .error_code(error_code), .cfg_err(cfg_err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model
    int         m_state;
    logic [4:0] m_lo [5];
    logic [4:0] m_hi [5];
    logic [4:0] m_code;
    logic       m_cfg;
    int         total;
    int         passes;

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < 5; i++) begin
            m_lo[i] = '0;
            m_hi[i] = '0;
        end
        m_code = '0;
        m_cfg  = 1'b0;
    endtask

    task automatic model_step();
        bit bad;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_state == 0) begin
            m_state = 1;
            return;
        end
        if (m_state == 4) begin
            m_code |= errors;
            return;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) if (lo_i[i] > hi_i[i]) bad = 1;
        if (m_state == 1) begin
            for (int i = 0; i < 5; i++) begin
                m_lo[i] = lo_i[i];
                m_hi[i] = hi_i[i];
            end
        end
        if (errors != 0) begin
            m_state = 4;
            m_code |= errors;
        end else if (init) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_state = bad ? 4 : 2;
            m_cfg   = m_cfg | bad;
        end else begin
            m_state = (empties == 5'h1F) ? 2 : 3;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(string step);
        chk({step, " state"}, 32'(state), 32'(m_state));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s lo_out[%0d]", step, i), 32'(lo_o[i]), 32'(m_lo[i]));
            chk($sformatf("%s hi_out[%0d]", step, i), 32'(hi_o[i]), 32'(m_hi[i]));
        end
        chk({step, " idle_out"}, 32'(idle_out), 32'(m_state == 2));
        chk({step, " active_out"}, 32'(active_out), 32'(m_state == 3));
        chk({step, " error_out"}, 32'(error_out), 32'(m_state == 4));
        chk({step, " error_code"}, 32'(error_code), 32'(m_code));
        chk({step, " cfg_err"}, 32'(cfg_err), 32'(m_cfg));
    endtask

    // driver tasks
    task automatic tick(string step);
        @(posedge clk);
        model_step();
        #1;
        check_all(step);
    endtask

    task automatic set_th(input logic [4:0] lo [5], input logic [4:0] hi [5]);
        for (int i = 0; i < 5; i++) begin
            lo_i[i] = lo[i];
            hi_i[i] = hi[i];
        end
    endtask

    task automatic do_reset(string step);
        reset = 1'b1;
        #1;
        model_reset();
        check_all({step, " async"});
        tick({step, " held"});
        reset = 1'b0;
        #1;
        check_all({step, " released"});
    endtask

    logic [4:0] t2_lo [5] = '{5'h3, 5'hB, 5'hA, 5'hC, 5'hD};
    logic [4:0] t2_hi [5] = '{5'h6, 5'h8, 5'h7, 5'h9, 5'hA};
    logic [4:0] t3_lo [5] = '{5'h3, 5'h2, 5'h1, 5'h4, 5'h0};
    logic [4:0] t3_hi [5] = '{5'h6, 5'h8, 5'h7, 5'h9, 5'hA};
    logic [4:0] zero5 [5] = '{5'h0, 5'h0, 5'h0, 5'h0, 5'h0};

    initial begin
        total = 0;
        passes = 0;
        init = 0;
        empties = 5'h1F;
        errors = 0;
        set_th(zero5, zero5);
        model_reset();
        reset = 1'b1;
        #1;
        check_all("t1 reset");
        @(posedge clk);
        #1;
        check_all("t1 reset c1");
        @(posedge clk);
        #1;
        check_all("t1 reset c2");
        reset = 1'b0;
        tick("t1 init");
        tick("t1 idle");

        // invalid thresholds
        do_reset("t2 rst");
        init = 1;
        set_th(t2_lo, t2_hi);
        tick("t2 enter init");
        tick("t2 latch");
        tick("t2 latch2");
        init = 0;
        tick("t2 cfg_err");
        tick("t2 sticky");

        // valid thresholds, then frozen outside INIT
        do_reset("t3 rst");
        tick("t3 to init");
        init = 1;
        set_th(t3_lo, t3_hi);
        tick("t3 latch");
        init = 0;
        tick("t3 idle");
        set_th(zero5, zero5);
        tick("t3 frozen");

        // IDLE <-> ACTIVE
        empties = 5'h1E;
        tick("t4 active");
        empties = 5'h1F;
        tick("t4 idle");
        empties = 5'h00;
        tick("t4 active2");

        // error accumulation with simultaneous init
        errors = 5'h01;
        tick("t5 err1");
        errors = 5'h04;
        init = 1;
        tick("t5 err2");
        errors = 0;
        init = 0;
        tick("t5 sticky");

        // async reset mid-cycle while in ERROR
        #2;
        do_reset("t6 rst");
        tick("t6 init");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if (m_state == 4 && $urandom_range(0, 3) == 0) begin
                #($urandom_range(1, 3));
                do_reset("rnd rst");
            end
            init = ($urandom_range(0, 3) == 0);
            errors = ($urandom_range(0, 24) == 0) ? 5'($urandom_range(1, 31)) : 5'h0;
            empties = ($urandom_range(0, 1) == 0) ? 5'h1F : 5'($urandom_range(0, 31));
            for (int i = 0; i < 5; i++) begin
                lo_i[i] = 5'($urandom_range(0, 20));
                hi_i[i] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31))
                                                       : lo_i[i] + 5'($urandom_range(0, 11));
            end
            tick("rnd");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/fsm_flow_ctrl.md
Name: fsm_flow_ctrl

Overview:
Flow-control state machine that consumes the configuration and status stimulus generated by the FSM probe: init strobe, low/high watermark thresholds for main FIFO, VC0, VC1, D0 and D1, per-FIFO empty flags and per-FIFO error flags. It captures the thresholds during INIT and validates them when INIT ends. It tracks IDLE/ACTIVE from the empty flags and enters a sticky ERROR state on any FIFO error. Downstream FIFO logic uses its latched thresholds and status outputs.

Parameters:
TH_W, 5, threshold width in bits
N_FIFO, 5, number of monitored FIFOs (main, vc0, vc1, d0, d1; bit order 0..4)

Ports:
clk  input  1  single system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
init  input  1  configuration request; thresholds are captured while high
main_fifo_low, main_fifo_high  input  TH_W  main FIFO watermarks
vc0_low, vc0_high  input  TH_W  VC0 watermarks
vc1_low, vc1_high  input  TH_W  VC1 watermarks
d0_low, d0_high  input  TH_W  D0 watermarks
d1_low, d1_high  input  TH_W  D1 watermarks
empties  input  N_FIFO  per-FIFO empty flag, 1 = empty
errors  input  N_FIFO  per-FIFO error flag, 1 = error
state  output  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
main_fifo_low_out, main_fifo_high_out, vc0_low_out, vc0_high_out, vc1_low_out, vc1_high_out, d0_low_out, d0_high_out, d1_low_out, d1_high_out  output  TH_W each  latched thresholds
idle_out  output  1  high in IDLE
active_out  output  1  high in ACTIVE
error_out  output  1  high in ERROR
error_code  output  N_FIFO  sticky OR of errors sampled in ERROR entry/ERROR
cfg_err  output  1  sticky: thresholds invalid at INIT exit

Behaviour:
- Reset is asynchronous and active-high. While reset=1: state=RESET, all *_out=0, idle_out=active_out=error_out=0, error_code=0, cfg_err=0.
- All outputs are registered. They reflect a condition sampled at posedge N starting from posedge N, so they are visible in cycle N+1.
- Priority in every non-RESET state: errors!=0 beats init, and init beats empties.
- RESET: with reset low, goes to INIT at the first posedge.
- INIT: every cycle, latch all ten threshold inputs into their *_out registers.
  - errors!=0 -> ERROR.
  - init=1 -> stay in INIT.
  - init=0: validate the values being latched. If any pair has low>high -> ERROR with cfg_err=1. Otherwise -> IDLE.
  - low==high is valid.
- IDLE: errors!=0 -> ERROR; init=1 -> INIT; empties!=all-ones -> ACTIVE; else stay.
- ACTIVE: errors!=0 -> ERROR; init=1 -> INIT; empties==all-ones -> IDLE; else stay.
- ERROR: absorbing; only reset exits.
  - error_code |= errors every cycle, including the entry edge.
  - *_out are frozen in ERROR, IDLE and ACTIVE; only INIT updates them.
- Status flags: idle_out = (state==IDLE); active_out = (state==ACTIVE); error_out = (state==ERROR). Exactly one or none is high.
- Simultaneous events:
  - errors and init in the same cycle -> ERROR.
  - Reset asserted mid-INIT clears the latched thresholds immediately (asynchronously).
- Threshold inputs changing outside INIT have no effect on *_out.

Test Plan:
1. Assert reset 2 cycles, then release with init=0, errors=0, empties=5'h1F -> state 0 during reset, 1 after first edge, 2 (idle_out=1) after second edge; all *_out=0.
2. init=1 with main_fifo 3/6, vc0 B/8, vc1 A/7, d0 C/9, d1 D/A -> *_out track inputs while in INIT. Drop init -> cfg_err=1 and state=4, because vc0/vc1/d0/d1 have low>high.
3. Reset, then init=1 with main 3/6, vc0 2/8, vc1 1/7, d0 4/9, d1 0/A, then init=0 -> state=2. Change all inputs to 0 -> *_out unchanged (3,6,2,8,...).
4. From IDLE, empties=5'h1E -> state=3, active_out=1 next cycle. empties=5'h1F -> back to 2.
5. From ACTIVE, errors=5'h01, then errors=5'h04 next cycle, with init=1 simultaneously -> state=4, error_code=5'h05, error_out=1. The state stays 4 after errors clear.
6. Assert reset asynchronously mid-cycle while in ERROR -> all outputs 0 immediately, before the next edge. Release -> state 0 -> 1.
